// File: rtl/int_issue_queue.sv
// Integer issue queue: collapsing, oldest-first select, CDB wakeup, valid/ready issue port.
// Optional CDB_BYPASS_EN: forward the live CDB into select for zero-latency wakeup-to-issue.
module int_issue_queue #(
    parameter int DATA_WIDTH   = 32,
    parameter int TAG_WIDTH    = 6,
    parameter int OPCODE_WIDTH = 4,
    parameter int DEPTH        = 4,
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dispatch_en_integer,
    input  logic [OPCODE_WIDTH-1:0] dispatch_opcode,
    input  logic [TAG_WIDTH-1:0]    dispatch_rd_tag,
    input  logic [DATA_WIDTH-1:0]   dispatch_rs1_data,
    input  logic [TAG_WIDTH-1:0]    dispatch_rs1_tag,
    input  logic                    dispatch_rs1_valid,
    input  logic [DATA_WIDTH-1:0]   dispatch_rs2_data,
    input  logic [TAG_WIDTH-1:0]    dispatch_rs2_tag,
    input  logic                    dispatch_rs2_valid,
    input  logic                    CDB_valid,
    input  logic [TAG_WIDTH-1:0]    CDB_tag,
    input  logic [DATA_WIDTH-1:0]   CDB_data,
    input  logic                    flush,
    output logic                    issueque_full_integer,
    output logic                    issue_valid,
    input  logic                    issue_ready,
    output logic [OPCODE_WIDTH-1:0] issue_opcode,
    output logic [TAG_WIDTH-1:0]    issue_rd_tag,
    output logic [DATA_WIDTH-1:0]   issue_rs1_data,
    output logic [DATA_WIDTH-1:0]   issue_rs2_data,
    output logic [CNT_W-1:0]        issue_count
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic                    vld;
        logic [OPCODE_WIDTH-1:0] opc;
        logic [TAG_WIDTH-1:0]    rd;
        logic                    r1_rdy;
        logic [TAG_WIDTH-1:0]    r1_tag;
        logic [DATA_WIDTH-1:0]   r1_dat;
        logic                    r2_rdy;
        logic [TAG_WIDTH-1:0]    r2_tag;
        logic [DATA_WIDTH-1:0]   r2_dat;
    } entry_t;

    entry_t              ent_q [DEPTH];
    entry_t              ent_d [DEPTH];
    entry_t              woke  [DEPTH+1];
    entry_t              new_ent;
    entry_t              sel_ent;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                hold_q, hold_d;
    logic [IDX_W-1:0]    hold_idx_q, hold_idx_d;
    logic [DEPTH-1:0]    elig;
    logic [IDX_W-1:0]    sel_idx;
    logic                sel_vld;
    logic                full, fire, acc;
    logic [CNT_W-1:0]    wr_slot;

    assign full                  = (count_q == CNT_W'(DEPTH));
    assign issueque_full_integer = full;
    assign issue_count           = count_q;

    // Entries as they look after this cycle's CDB snoop; the extra slot feeds the collapse shift.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = ent_q[i];
            if (ent_q[i].vld && CDB_valid) begin
                if (!ent_q[i].r1_rdy && ent_q[i].r1_tag == CDB_tag) begin
                    woke[i].r1_rdy = 1'b1;
                    woke[i].r1_dat = CDB_data;
                end
                if (!ent_q[i].r2_rdy && ent_q[i].r2_tag == CDB_tag) begin
                    woke[i].r2_rdy = 1'b1;
                    woke[i].r2_dat = CDB_data;
                end
            end
        end
        woke[DEPTH] = '0;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
`ifdef CDB_BYPASS_EN
            elig[i] = ent_q[i].vld && woke[i].r1_rdy && woke[i].r2_rdy;
`else
            elig[i] = ent_q[i].vld && ent_q[i].r1_rdy && ent_q[i].r2_rdy;
`endif
        end
        sel_idx = '0;
        sel_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (elig[i] && !sel_vld) begin
                sel_idx = IDX_W'(i);
                sel_vld = 1'b1;
            end
        end
        // A stalled issue keeps its entry even if an older one wakes up meanwhile.
        if (hold_q) begin
            sel_idx = hold_idx_q;
            sel_vld = elig[hold_idx_q];
        end
        sel_ent        = woke[sel_idx];
        issue_valid    = sel_vld;
        issue_opcode   = sel_vld ? sel_ent.opc    : '0;
        issue_rd_tag   = sel_vld ? sel_ent.rd     : '0;
        issue_rs1_data = sel_vld ? sel_ent.r1_dat : '0;
        issue_rs2_data = sel_vld ? sel_ent.r2_dat : '0;
    end

    always_comb begin
        fire    = issue_valid && issue_ready;
        acc     = dispatch_en_integer && !full && !flush;
        wr_slot = count_q - CNT_W'(fire);

        new_ent        = '0;
        new_ent.vld    = 1'b1;
        new_ent.opc    = dispatch_opcode;
        new_ent.rd     = dispatch_rd_tag;
        new_ent.r1_tag = dispatch_rs1_tag;
        new_ent.r2_tag = dispatch_rs2_tag;
        if (dispatch_rs1_valid) begin
            new_ent.r1_rdy = 1'b1;
            new_ent.r1_dat = dispatch_rs1_data;
        end else if (CDB_valid && CDB_tag == dispatch_rs1_tag) begin
            new_ent.r1_rdy = 1'b1;
            new_ent.r1_dat = CDB_data;
        end
        if (dispatch_rs2_valid) begin
            new_ent.r2_rdy = 1'b1;
            new_ent.r2_dat = dispatch_rs2_data;
        end else if (CDB_valid && CDB_tag == dispatch_rs2_tag) begin
            new_ent.r2_rdy = 1'b1;
            new_ent.r2_dat = CDB_data;
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (fire && i >= int'(sel_idx)) ent_d[i] = woke[i+1];
            else                            ent_d[i] = woke[i];
            if (acc && i == int'(wr_slot))  ent_d[i] = new_ent;
            if (flush)                      ent_d[i] = '0;
        end

        count_d    = flush ? '0 : count_q - CNT_W'(fire) + CNT_W'(acc);
        hold_d     = issue_valid && !issue_ready && !flush;
        hold_idx_d = sel_idx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            count_q    <= '0;
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            count_q    <= count_d;
            hold_q     <= hold_d;
            hold_idx_q <= hold_idx_d;
        end
    end
endmodule

// File: tb/tb_int_issue_queue.sv
// Bench for int_issue_queue: directed vector table, latency/reset sequences, randomized run vs queue model.
module tb_int_issue_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        dispatch_en_integer;
    logic [3:0]  dispatch_opcode;
    logic [5:0]  dispatch_rd_tag;
    logic [31:0] dispatch_rs1_data;
    logic [5:0]  dispatch_rs1_tag;
    logic        dispatch_rs1_valid;
    logic [31:0] dispatch_rs2_data;
    logic [5:0]  dispatch_rs2_tag;
    logic        dispatch_rs2_valid;
    logic        CDB_valid;
    logic [5:0]  CDB_tag;
    logic [31:0] CDB_data;
    logic        flush;
    logic        issueque_full_integer;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  issue_opcode;
    logic [5:0]  issue_rd_tag;
    logic [31:0] issue_rs1_data;
    logic [31:0] issue_rs2_data;
    logic [2:0]  issue_count;

    int checks = 0;
    int errors = 0;

    int_issue_queue dut (
        .clk(clk), .reset(reset),
        .dispatch_en_integer(dispatch_en_integer), .dispatch_opcode(dispatch_opcode),
        .dispatch_rd_tag(dispatch_rd_tag),
        .dispatch_rs1_data(dispatch_rs1_data), .dispatch_rs1_tag(dispatch_rs1_tag),
        .dispatch_rs1_valid(dispatch_rs1_valid),
        .dispatch_rs2_data(dispatch_rs2_data), .dispatch_rs2_tag(dispatch_rs2_tag),
        .dispatch_rs2_valid(dispatch_rs2_valid),
        .CDB_valid(CDB_valid), .CDB_tag(CDB_tag), .CDB_data(CDB_data), .flush(flush),
        .issueque_full_integer(issueque_full_integer), .issue_valid(issue_valid),
        .issue_ready(issue_ready), .issue_opcode(issue_opcode), .issue_rd_tag(issue_rd_tag),
        .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
        .issue_count(issue_count)
    );

    always #5 clk = ~clk;

`ifdef CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        bit en; logic [5:0] rd;
        bit r1v; logic [5:0] r1t; bit r2v; logic [5:0] r2t;
        bit cv; logic [5:0] ct; logic [31:0] cd;
        bit rdy; bit fl;
        int e_cnt; bit e_full; bit e_iv; logic [5:0] e_rd; logic [31:0] e_r1; logic [31:0] e_r2;
    } vec_t;

    function automatic vec_t row(bit en, logic [5:0] rd, bit r1v, logic [5:0] r1t, bit r2v,
                                 logic [5:0] r2t, bit cv, logic [5:0] ct, logic [31:0] cd,
                                 bit rdy, bit fl, int e_cnt, bit e_full, bit e_iv,
                                 logic [5:0] e_rd, logic [31:0] e_r1, logic [31:0] e_r2);
        vec_t v;
        v.en = en; v.rd = rd; v.r1v = r1v; v.r1t = r1t; v.r2v = r2v; v.r2t = r2t;
        v.cv = cv; v.ct = ct; v.cd = cd; v.rdy = rdy; v.fl = fl;
        v.e_cnt = e_cnt; v.e_full = e_full; v.e_iv = e_iv; v.e_rd = e_rd;
        v.e_r1 = e_r1; v.e_r2 = e_r2;
        return v;
    endfunction

    task automatic idle();
        dispatch_en_integer = 0; dispatch_opcode = 0; dispatch_rd_tag = 0;
        dispatch_rs1_data = 0; dispatch_rs1_tag = 0; dispatch_rs1_valid = 0;
        dispatch_rs2_data = 0; dispatch_rs2_tag = 0; dispatch_rs2_valid = 0;
        CDB_valid = 0; CDB_tag = 0; CDB_data = 0; flush = 0; issue_ready = 0;
    endtask

    task automatic check(string name, bit iv, int cnt, bit full, logic [5:0] rd,
                         logic [3:0] opc, logic [31:0] r1, logic [31:0] r2);
        checks++;
        if (issue_valid !== iv || int'(issue_count) != cnt || issueque_full_integer !== full ||
            issue_rd_tag !== rd || issue_opcode !== opc || issue_rs1_data !== r1 ||
            issue_rs2_data !== r2) begin
            errors++;
            $display("FAIL %s: got iv=%0b cnt=%0d full=%0b rd=%0d opc=%0h rs1=%h rs2=%h; want iv=%0b cnt=%0d full=%0b rd=%0d opc=%0h rs1=%h rs2=%h",
                     name, issue_valid, issue_count, issueque_full_integer, issue_rd_tag,
                     issue_opcode, issue_rs1_data, issue_rs2_data, iv, cnt, full, rd, opc, r1, r2);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [3:0] opc; logic [5:0] rd;
        bit r1r; logic [5:0] r1t; logic [31:0] r1d;
        bit r2r; logic [5:0] r2t; logic [31:0] r2d;
    } ment_t;
    ment_t mq[$];
    bit    mhold = 0;
    int    mhidx = 0;
    bit          e_iv;
    logic [3:0]  e_opc;
    logic [5:0]  e_rd;
    logic [31:0] e_r1, e_r2;
    int          e_sel;

    task automatic model_out();
        e_iv = 0; e_opc = 0; e_rd = 0; e_r1 = 0; e_r2 = 0; e_sel = -1;
        for (int i = 0; i < mq.size(); i++) begin
            bit a, b;
            logic [31:0] d1, d2;
            a = mq[i].r1r; b = mq[i].r2r; d1 = mq[i].r1d; d2 = mq[i].r2d;
            if (BYP && CDB_valid) begin
                if (!a && CDB_tag == mq[i].r1t) begin a = 1; d1 = CDB_data; end
                if (!b && CDB_tag == mq[i].r2t) begin b = 1; d2 = CDB_data; end
            end
            if (a && b && (mhold ? (i == mhidx) : (e_sel < 0))) begin
                e_sel = i; e_iv = 1; e_opc = mq[i].opc; e_rd = mq[i].rd; e_r1 = d1; e_r2 = d2;
            end
        end
    endtask

    task automatic model_step();
        bit fire, acc;
        ment_t t;
        fire = e_iv && issue_ready;
        if (flush) begin
            mq.delete();
            mhold = 0;
            return;
        end
        acc = dispatch_en_integer && (mq.size() < DEPTH);
        for (int i = 0; i < mq.size(); i++) begin
            t = mq[i];
            if (CDB_valid && !t.r1r && t.r1t == CDB_tag) begin t.r1r = 1; t.r1d = CDB_data; end
            if (CDB_valid && !t.r2r && t.r2t == CDB_tag) begin t.r2r = 1; t.r2d = CDB_data; end
            mq[i] = t;
        end
        if (fire) mq.delete(e_sel);
        if (acc) begin
            t.opc = dispatch_opcode; t.rd = dispatch_rd_tag;
            t.r1t = dispatch_rs1_tag; t.r2t = dispatch_rs2_tag;
            t.r1r = dispatch_rs1_valid || (CDB_valid && CDB_tag == dispatch_rs1_tag);
            t.r1d = dispatch_rs1_valid ? dispatch_rs1_data : (t.r1r ? CDB_data : 32'h0);
            t.r2r = dispatch_rs2_valid || (CDB_valid && CDB_tag == dispatch_rs2_tag);
            t.r2d = dispatch_rs2_valid ? dispatch_rs2_data : (t.r2r ? CDB_data : 32'h0);
            mq.push_back(t);
        end
        mhold = e_iv && !issue_ready;
        mhidx = e_sel;
    endtask

    vec_t vt[$];

    initial begin
        idle();
        reset = 1;
        #3;
        check("reset_state", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 0;

        // Directed table; each row is applied for one edge, then outputs checked with idle inputs.
        vt.push_back(row(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 32'h101, 32'h201));
        vt.push_back(row(1, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1, 1, 32'h101, 32'h201));
        vt.push_back(row(1, 3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 1, 1, 32'h101, 32'h201));
        vt.push_back(row(1, 4, 1, 0, 1, 0, 0, 0, 0, 0, 0, 4, 1, 1, 1, 32'h101, 32'h201));
        vt.push_back(row(1, 5, 1, 0, 1, 0, 0, 0, 0, 0, 0, 4, 1, 1, 1, 32'h101, 32'h201));
        vt.push_back(row(1, 6, 1, 0, 1, 0, 0, 0, 0, 1, 0, 3, 0, 1, 2, 32'h102, 32'h202));
        vt.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vt.push_back(row(1, 7, 0, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vt.push_back(row(0, 0, 0, 0, 0, 0, 1, 9, 32'hDEAD_BEEF, 0, 0, 1, 0, 1, 7, 32'hDEAD_BEEF, 32'h207));
        vt.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(row(1, 10, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vt.push_back(row(1, 11, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1, 11, 32'h10B, 32'h20B));
        vt.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        vt.push_back(row(0, 0, 0, 0, 0, 0, 1, 3, 32'h33, 0, 0, 1, 0, 1, 10, 32'h33, 32'h20A));
        vt.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(row(1, 12, 1, 0, 0, 5, 1, 5, 32'h55, 0, 0, 1, 0, 1, 12, 32'h10C, 32'h55));
        vt.push_back(row(1, 13, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1, 12, 32'h10C, 32'h55));
        vt.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        for (int r = 0; r < vt.size(); r++) begin
            @(negedge clk);
            dispatch_en_integer = vt[r].en; dispatch_rd_tag = vt[r].rd;
            dispatch_opcode = vt[r].rd[3:0];
            dispatch_rs1_valid = vt[r].r1v; dispatch_rs1_tag = vt[r].r1t;
            dispatch_rs1_data = 32'h100 + 32'(vt[r].rd);
            dispatch_rs2_valid = vt[r].r2v; dispatch_rs2_tag = vt[r].r2t;
            dispatch_rs2_data = 32'h200 + 32'(vt[r].rd);
            CDB_valid = vt[r].cv; CDB_tag = vt[r].ct; CDB_data = vt[r].cd;
            issue_ready = vt[r].rdy; flush = vt[r].fl;
            @(posedge clk);
            #1 idle();
            #1 check($sformatf("table_row%0d", r), vt[r].e_iv, vt[r].e_cnt, vt[r].e_full,
                     vt[r].e_rd, vt[r].e_iv ? vt[r].e_rd[3:0] : 4'h0, vt[r].e_r1, vt[r].e_r2);
        end

        // Wakeup-to-issue latency: bypass build issues in the CDB cycle itself.
        @(negedge clk);
        dispatch_en_integer = 1; dispatch_rd_tag = 7; dispatch_opcode = 4'h7;
        dispatch_rs1_tag = 9; dispatch_rs2_valid = 1; dispatch_rs2_data = 32'h77;
        @(negedge clk);
        idle();
        CDB_valid = 1; CDB_tag = 9; CDB_data = 32'hDEAD_BEEF;
        #1;
        if (BYP) check("cdb_same_cycle", 1, 1, 0, 7, 4'h7, 32'hDEAD_BEEF, 32'h77);
        else     check("cdb_same_cycle", 0, 1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 idle();
        #1 check("cdb_next_cycle", 1, 1, 0, 7, 4'h7, 32'hDEAD_BEEF, 32'h77);
        @(negedge clk);
        flush = 1;
        @(posedge clk);
        #1 idle();
        #1 check("flush_clear", 0, 0, 0, 0, 0, 0, 0);
        mq.delete();
        mhold = 0;

        // Randomized run against the queue model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            dispatch_en_integer = ($urandom_range(0, 9) < 6);
            dispatch_opcode    = 4'($urandom);
            dispatch_rd_tag    = 6'($urandom);
            dispatch_rs1_valid = $urandom_range(0, 1) == 1;
            dispatch_rs1_tag   = 6'($urandom_range(0, 7));
            dispatch_rs1_data  = $urandom;
            dispatch_rs2_valid = $urandom_range(0, 1) == 1;
            dispatch_rs2_tag   = 6'($urandom_range(0, 7));
            dispatch_rs2_data  = $urandom;
            CDB_valid   = ($urandom_range(0, 9) < 4);
            CDB_tag     = 6'($urandom_range(0, 7));
            CDB_data    = $urandom;
            issue_ready = $urandom_range(0, 1) == 1;
            flush       = ($urandom_range(0, 49) == 0);
            #1;
            model_out();
            check($sformatf("random_cyc%0d", c), e_iv, mq.size(), mq.size() == DEPTH,
                  e_rd, e_opc, e_r1, e_r2);
            @(posedge clk);
            model_step();
        end

        // Async reset mid-cycle with three entries held.
        @(negedge clk);
        idle();
        flush = 1;
        @(negedge clk);
        idle();
        for (int k = 0; k < 3; k++) begin
            dispatch_en_integer = 1; dispatch_rd_tag = 6'(20 + k); dispatch_opcode = 4'(k);
            dispatch_rs1_valid = 1; dispatch_rs2_valid = 1;
            dispatch_rs1_data = 32'(k); dispatch_rs2_data = 32'(k);
            @(negedge clk);
        end
        idle();
        #1 check("pre_reset_count3", 1, 3, 0, 20, 4'h0, 0, 0);
        #1 reset = 1;
        #1 check("async_reset", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
